// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
//   - Opcode encodings for the 3-bit op field.
//   - FSM state type used by alu_seq (IDLE for single-cycle ops, MUL while
//     the iterative multiplier is busy).
package alu_pkg;

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_OR    = 3'b001;
  localparam logic [2:0] OP_XOR   = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_SUB   = 3'b100;
  localparam logic [2:0] OP_SLT   = 3'b101;
  localparam logic [2:0] OP_MUL   = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier, one partial product per cycle.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (aborts any operation)
//   start_i     : load operands and begin; ignored bits are don't-care
//   a_i, b_i    : multiplicand / multiplier, WIDTH bits unsigned
//   done_o      : high during the cycle whose rising edge completes the last step
//   product_o   : full 2*WIDTH product, valid whenever done_o is high
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CNT_W = $clog2(WIDTH);

  logic               busy_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_d;

  // The final partial product is folded in combinationally so the product is
  // ready on the same edge that completes the last iteration.
  assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o    = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
  assign product_o = acc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (done_o) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes on both sides.
// Single-cycle ops (AND/OR/XOR/ADD/SUB/SLT/PASSB) produce a registered result
// one edge after accept; MUL runs WIDTH cycles in alu_mul_seq.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : request handshake; op, a, b sampled on accept
//   out_valid / out_ready : result handshake; outputs held while stalled
//   result                : low WIDTH bits of the operation
//   carry                 : ADD carry-out, SUB borrow, MUL high-half non-zero
//   zero                  : result == 0
//   eq                    : accepted a == accepted b
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             eq
);

  state_t             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               eq_q, eq_d;
  logic               mul_eq_q;

  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;

  // rst_n is folded in so in_ready reads 0 while reset is held, even though
  // the registered state already looks idle.
  assign in_ready  = rst_n && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == OP_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (mul_start),
    .a_i       (a),
    .b_i       (b),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  // Single-cycle datapath; the borrow bit of diff doubles as the a<b compare.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    sum       = {1'b0, a} + {1'b0, b};
    diff      = {1'b0, a} - {1'b0, b};
    case (op)
      OP_AND:   alu_res = a & b;
      OP_OR:    alu_res = a | b;
      OP_XOR:   alu_res = a ^ b;
      OP_ADD:   begin alu_res = sum[WIDTH-1:0];  alu_carry = sum[WIDTH];  end
      OP_SUB:   begin alu_res = diff[WIDTH-1:0]; alu_carry = diff[WIDTH]; end
      OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
      OP_PASSB: alu_res = b;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mul_start) state_d = ST_MUL;
      ST_MUL:  if (mul_done)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A load on the same edge as a consume keeps out_valid high with new data.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    eq_d        = eq_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (accept && (op != OP_MUL)) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      carry_d     = alu_carry;
      zero_d      = (alu_res == '0);
      eq_d        = (a == b);
    end else if ((state_q == ST_MUL) && mul_done) begin
      out_valid_d = 1'b1;
      result_d    = mul_product[WIDTH-1:0];
      carry_d     = |mul_product[2*WIDTH-1:WIDTH];
      zero_d      = (mul_product[WIDTH-1:0] == '0);
      eq_d        = mul_eq_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      eq_q        <= 1'b0;
      mul_eq_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      eq_q        <= eq_d;
      // Operands are gone by the time the product is ready, so a==b is kept.
      if (mul_start) mul_eq_q <= (a == b);
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign eq        = eq_q;

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  operation request present.
REQ-005 Port: in_ready  output  1  block can accept a request this cycle.
REQ-006 Port: op  input  3  opcode, sampled on accept.
REQ-007 Port: a  input  WIDTH  operand A, unsigned, sampled on accept.
REQ-008 Port: b  input  WIDTH  operand B, unsigned, sampled on accept.
REQ-009 Port: out_valid  output  1  result/flags valid.
REQ-010 Port: out_ready  input  1  consumer takes the result this cycle.
REQ-011 Port: result  output  WIDTH  operation result.
REQ-012 Port: carry  output  1  carry/borrow/overflow flag.
REQ-013 Port: zero  output  1  result == 0.
REQ-014 Port: eq  output  1  a == b for the accepted operands.

Function
REQ-015 The block SHALL accept a request on a rising edge where in_valid && in_ready.
REQ-016 The opcodes SHALL be: 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB (a-b), 101 SLT (result = 1 if a<b unsigned, else 0), 110 MUL, 111 PASSB (result = b).
REQ-017 carry SHALL be: ADD carry-out; SUB borrow (a<b); MUL OR-reduction of upper WIDTH bits of the 2*WIDTH product; 0 for all other opcodes.
REQ-018 result SHALL be the low WIDTH bits of the operation, with wrap-around on ADD/SUB/MUL.
REQ-019 zero and eq SHALL be computed for every opcode and registered together with result.
REQ-020 in_ready SHALL equal (state == IDLE) && (!out_valid || out_ready), combinationally.
REQ-021 Non-MUL opcodes SHALL have latency 1: accept at edge k -> out_valid high after edge k.
REQ-022 MUL SHALL run an iterative shift-add over WIDTH cycles: accept at edge k -> out_valid high after edge k+WIDTH; in_ready SHALL be 0 throughout.
REQ-023 FSM states SHALL be IDLE and MUL; IDLE->MUL on accept of op 110; MUL->IDLE on the edge the iteration counter reaches WIDTH-1, loading the output register on that edge.
REQ-024 Output registers SHALL hold result/flags stable while out_valid && !out_ready.
REQ-025 out_valid SHALL clear on an edge with out_valid && out_ready unless a new result loads on that same edge, in which case it SHALL stay high with the new data (throughput one non-MUL op per cycle).
REQ-026 a, b and op changes while not accepted SHALL have no effect.

Reset
REQ-027 While rst_n is low: state = IDLE, counter = 0, out_valid = 0, result = 0, carry = 0, zero = 0, eq = 0, in_ready = 0.
REQ-028 Reset asserted during MUL SHALL abort the operation; no result SHALL appear after release.
REQ-029 in_ready SHALL go high on the first cycle after rst_n deasserts.

Structure
REQ-030 Opcode localparams and the FSM state type SHALL live in shared package alu_pkg.
REQ-031 The iterative multiplier (start, operands, done, 2*WIDTH product) SHALL be sub-module alu_mul_seq; all other opcodes SHALL be inline combinational logic.

Verification
REQ-032 WIDTH=2, a=2, b=3, ADD -> result=1, carry=1, zero=0, eq=0, out_valid one cycle after accept.
REQ-033 WIDTH=2, a=2, b=3, SUB -> result=3, carry=1; a=3, b=3, SUB -> result=0, zero=1, eq=1.
REQ-034 WIDTH=8, a=200, b=3, MUL -> result=88, carry=1, out_valid exactly 8 cycles after accept, in_ready=0 during those cycles.
REQ-035 WIDTH=8, out_ready held 0 for 5 cycles after an XOR of 0xF0 and 0x0F -> result=0xFF held stable, in_ready=0; out_ready=1 with new in_valid -> back-to-back results on consecutive cycles.
REQ-036 rst_n pulsed low 3 cycles into a WIDTH=8 MUL -> all outputs 0 immediately, no out_valid after release, in_ready=1 next cycle.
